multi_cycle_control: RTL and testbench

//  Multi-cycle controller that produces the ALU control code and datapath strobes for the 64-bit LEGv8 datapath.

---
 rtl/legv8_pkg.sv | 47 ++++
 rtl/alu_ctrl_decode.sv | 45 ++++
 rtl/multi_cycle_control.sv | 158 +++++++++++++++
 tb/tb_multi_cycle_control.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared LEGv8 opcode, ALU control and controller state definitions
// Purpose: opcode patterns and masks, ALUCtrl codes, instruction classes and
//          multi-cycle controller states, shared by the single- and multi-cycle cores.
// Ports:   none (package).
package legv8_pkg;

  localparam int OP_W  = 11;
  localparam int ALU_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 11'b10001011000;
  localparam logic [OP_W-1:0] OP_SUB  = 11'b11001011000;
  localparam logic [OP_W-1:0] OP_AND  = 11'b10001010000;
  localparam logic [OP_W-1:0] OP_ORR  = 11'b10101010000;
  localparam logic [OP_W-1:0] OP_LDUR = 11'b11111000010;
  localparam logic [OP_W-1:0] OP_STUR = 11'b11111000000;

  // CBZ and B carry immediate bits inside Instr[31:21]; only the masked bits identify them.
  localparam logic [OP_W-1:0] OP_CBZ      = 11'b10110100000;
  localparam logic [OP_W-1:0] OP_CBZ_MASK = 11'b11111111000;
  localparam logic [OP_W-1:0] OP_B        = 11'b00010100000;
  localparam logic [OP_W-1:0] OP_B_MASK   = 11'b11111100000;

  localparam logic [ALU_W-1:0] ALU_AND   = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_ORR   = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADD   = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SUB   = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_PASSB = 4'b0111;

  typedef enum logic [2:0] {
    CL_R,
    CL_LD,
    CL_ST,
    CL_CB,
    CL_UB,
    CL_ILL
  } instr_class_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational opcode to instruction class and ALUCtrl lookup
// Purpose: classifies an 11-bit LEGv8 opcode and gives the ALU operation it uses
//          in its execute step.
// Ports:   opcode_i   - opcode field Instr[31:21]
//          class_o    - instruction class (R, LD, ST, CB, UB, ILL)
//          alu_ctrl_o - ALUCtrl code for the execute step
module alu_ctrl_decode
  import legv8_pkg::*;
(
  input  logic [OP_W-1:0]  opcode_i,
  output instr_class_e     class_o,
  output logic [ALU_W-1:0] alu_ctrl_o
);

  always_comb begin
    class_o    = CL_ILL;
    alu_ctrl_o = ALU_AND;
    if (opcode_i == OP_ADD) begin
      class_o    = CL_R;
      alu_ctrl_o = ALU_ADD;
    end else if (opcode_i == OP_SUB) begin
      class_o    = CL_R;
      alu_ctrl_o = ALU_SUB;
    end else if (opcode_i == OP_AND) begin
      class_o    = CL_R;
      alu_ctrl_o = ALU_AND;
    end else if (opcode_i == OP_ORR) begin
      class_o    = CL_R;
      alu_ctrl_o = ALU_ORR;
    end else if (opcode_i == OP_LDUR) begin
      class_o    = CL_LD;
      alu_ctrl_o = ALU_ADD;
    end else if (opcode_i == OP_STUR) begin
      class_o    = CL_ST;
      alu_ctrl_o = ALU_ADD;
    end else if ((opcode_i & OP_CBZ_MASK) == OP_CBZ) begin
      class_o    = CL_CB;
      alu_ctrl_o = ALU_PASSB;
    end else if ((opcode_i & OP_B_MASK) == OP_B) begin
      class_o    = CL_UB;
      alu_ctrl_o = ALU_AND;
    end
  end

endmodule

// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - LEGv8 multi-cycle controller FSM with memory timeout trap
// Purpose: steps FETCH/DECODE/EXEC/MEM/WB, drives ALUCtrl and datapath strobes,
//          handshakes with instruction/data memory and traps on illegal opcode or timeout.
// Ports:   CLK, Reset_n (async active-low)
//          Opcode, InstrValid          - instruction memory side, sampled in FETCH
//          MemReady                    - data memory access completes
//          Zero                        - ALU zero flag, used by CBZ in EXEC
//          ALUCtrl, ALUSrc, Reg2Loc    - ALU / register read controls
//          IRWrite, MemRead, MemWrite  - instruction latch and data memory strobes
//          MemToReg, RegWrite          - write-back controls
//          PCWrite, PCSrc              - PC update and source select
//          Trap                        - sticky error flag
module multi_cycle_control
  import legv8_pkg::*;
#(
  parameter int OPCODE_W    = OP_W,
  parameter int CTRL_W      = ALU_W,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                CLK,
  input  logic                Reset_n,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                InstrValid,
  input  logic                MemReady,
  input  logic                Zero,
  output logic [CTRL_W-1:0]   ALUCtrl,
  output logic                ALUSrc,
  output logic                Reg2Loc,
  output logic                IRWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemToReg,
  output logic                RegWrite,
  output logic                PCWrite,
  output logic                PCSrc,
  output logic                Trap
);

  localparam int              CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  instr_class_e        cls;
  logic [ALU_W-1:0]    dec_alu;

  alu_ctrl_decode u_dec (
    .opcode_i   (opcode_q),
    .class_o    (cls),
    .alu_ctrl_o (dec_alu)
  );

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    cnt_d    = cnt_q;
    ALUCtrl  = ALU_AND;
    ALUSrc   = 1'b0;
    Reg2Loc  = 1'b0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    Trap     = 1'b0;

    case (state_q)
      S_FETCH: begin
        // Gated by Reset_n so every output reads 0 while reset is held.
        IRWrite = InstrValid & Reset_n;
        if (InstrValid) begin
          opcode_d = Opcode;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = (cls == CL_ILL) ? S_TRAP : S_EXEC;
      end

      S_EXEC: begin
        // The decoder already yields the per-class EXEC code (ADD for LD/ST, PassB for CB).
        ALUCtrl = dec_alu;
        case (cls)
          CL_R: state_d = S_WB;
          CL_LD, CL_ST: begin
            ALUSrc  = 1'b1;
            cnt_d   = '0;
            state_d = S_MEM;
          end
          CL_CB: begin
            Reg2Loc = 1'b1;
            PCWrite = 1'b1;
            PCSrc   = Zero;
            state_d = S_FETCH;
          end
          CL_UB: begin
            PCWrite = 1'b1;
            PCSrc   = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end

      S_MEM: begin
        ALUCtrl  = ALU_ADD;
        ALUSrc   = 1'b1;
        MemRead  = (cls == CL_LD);
        MemWrite = (cls == CL_ST);
        Reg2Loc  = (cls == CL_ST);
        // MemReady wins over the timeout when both land on the same cycle.
        if (MemReady) begin
          if (cls == CL_LD) begin
            state_d = S_WB;
          end else begin
            PCWrite = 1'b1;
            state_d = S_FETCH;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WB: begin
        RegWrite = 1'b1;
        MemToReg = (cls == CL_LD);
        PCWrite  = 1'b1;
        state_d  = S_FETCH;
      end

      S_TRAP: begin
        Trap = 1'b1;
      end

      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb/tb_multi_cycle_control.sv - scoreboard bench for multi_cycle_control
module tb_multi_cycle_control;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b0;
  logic [10:0] Opcode = '0;
  logic        InstrValid = 1'b0;
  logic        MemReady = 1'b0;
  logic        Zero = 1'b0;
  logic [3:0]  ALUCtrl;
  logic        ALUSrc, Reg2Loc, IRWrite, MemRead, MemWrite;
  logic        MemToReg, RegWrite, PCWrite, PCSrc, Trap;

  multi_cycle_control dut (
    .CLK        (CLK),
    .Reset_n    (Reset_n),
    .Opcode     (Opcode),
    .InstrValid (InstrValid),
    .MemReady   (MemReady),
    .Zero       (Zero),
    .ALUCtrl    (ALUCtrl),
    .ALUSrc     (ALUSrc),
    .Reg2Loc    (Reg2Loc),
    .IRWrite    (IRWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemToReg   (MemToReg),
    .RegWrite   (RegWrite),
    .PCWrite    (PCWrite),
    .PCSrc      (PCSrc),
    .Trap       (Trap)
  );

  always #5 CLK = ~CLK;

  localparam int MEM_TO = 16;
  localparam logic [13:0] ZV = 14'b0;

  // Bit order: Trap, ALUCtrl[3:0], ALUSrc, Reg2Loc, IRWrite, MemRead, MemWrite,
  //            MemToReg, RegWrite, PCWrite, PCSrc
  wire [13:0] act = {Trap, ALUCtrl, ALUSrc, Reg2Loc, IRWrite, MemRead, MemWrite,
                     MemToReg, RegWrite, PCWrite, PCSrc};

  logic [13:0] exp_q[$];
  string       tag_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef enum {K_R, K_LD, K_ST, K_CB, K_UB, K_ILL} kind_e;

  function automatic logic [13:0] ev(logic trap, logic [3:0] alu, logic asrc, logic r2l,
                                     logic irw, logic mr, logic mw, logic m2r, logic rw,
                                     logic pcw, logic pcs);
    return {trap, alu, asrc, r2l, irw, mr, mw, m2r, rw, pcw, pcs};
  endfunction

  function automatic kind_e classify(logic [10:0] op);
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return K_R;
    if (op == 11'b11111000010) return K_LD;
    if (op == 11'b11111000000) return K_ST;
    if (op[10:3] == 8'b10110100) return K_CB;
    if (op[10:5] == 6'b000101) return K_UB;
    return K_ILL;
  endfunction

  function automatic logic [3:0] r_code(logic [10:0] op);
    case (op)
      11'b10001011000: return 4'b0010;
      11'b11001011000: return 4'b0110;
      11'b10001010000: return 4'b0000;
      default:         return 4'b0001;
    endcase
  endfunction

  // One clock of stimulus: drive inputs just after the edge and queue the expected outputs.
  task automatic cyc(input logic rst, input logic iv, input logic [10:0] op, input logic mr,
                     input logic z, input logic [13:0] e, input string tag);
    @(posedge CLK);
    #1;
    Reset_n    = rst;
    InstrValid = iv;
    Opcode     = op;
    MemReady   = mr;
    Zero       = z;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  function automatic logic [10:0] rop();
    return 11'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic reset_pulse();
    cyc(1'b0, 1'b0, rop(), rb(), rb(), ZV, "reset");
    cyc(1'b1, 1'b0, rop(), rb(), rb(), ZV, "reset_release");
  endtask

  task automatic trap_cycles();
    int n;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++)
      cyc(1'b1, rb(), rop(), rb(), rb(), ev(1, 4'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "trap");
    reset_pulse();
  endtask

  // w: MEM cycles before MemReady (>= MEM_TO means never); zsel: 0/1 forces CBZ Zero, 2 random;
  // abort_at: MEM cycle index at which reset is pulled (-1 = no abort).
  task automatic run_instr(input logic [10:0] op, input int w, input int zsel, input int abort_at);
    kind_e k;
    logic  z, rdy, ld, st;
    int    idle;
    k = classify(op);
    idle = $urandom_range(0, 2);
    for (int i = 0; i < idle; i++)
      cyc(1'b1, 1'b0, rop(), rb(), rb(), ZV, "idle");
    cyc(1'b1, 1'b1, op, rb(), rb(), ev(0, 4'b0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "fetch");
    cyc(1'b1, rb(), rop(), rb(), rb(), ZV, "decode");
    case (k)
      K_ILL: trap_cycles();
      K_R: begin
        cyc(1'b1, rb(), rop(), rb(), rb(), ev(0, r_code(op), 0, 0, 0, 0, 0, 0, 0, 0, 0), "exec_r");
        cyc(1'b1, rb(), rop(), rb(), rb(), ev(0, 4'b0, 0, 0, 0, 0, 0, 0, 1, 1, 0), "wb_r");
      end
      K_CB: begin
        z = (zsel == 2) ? rb() : zsel[0];
        cyc(1'b1, rb(), rop(), rb(), z, ev(0, 4'b0111, 0, 1, 0, 0, 0, 0, 0, 1, z), "exec_cbz");
      end
      K_UB: cyc(1'b1, rb(), rop(), rb(), rb(), ev(0, 4'b0, 0, 0, 0, 0, 0, 0, 0, 1, 1), "exec_b");
      default: begin
        ld = (k == K_LD);
        st = (k == K_ST);
        cyc(1'b1, rb(), rop(), rb(), rb(), ev(0, 4'b0010, 1, 0, 0, 0, 0, 0, 0, 0, 0), "exec_mem");
        for (int i = 0; i < MEM_TO; i++) begin
          rdy = (i == w);
          if (i == abort_at) begin
            cyc(1'b0, 1'b0, rop(), rdy, rb(), ZV, "mem_abort");
            #1;
            n_cmp++;
            if (MemRead !== 1'b0 || MemWrite !== 1'b0) begin
              n_bad++;
              $display("FAIL async_abort: MemRead=%b MemWrite=%b, required 0/0", MemRead, MemWrite);
            end
            cyc(1'b1, 1'b0, rop(), rb(), rb(), ZV, "abort_release");
            return;
          end
          cyc(1'b1, rb(), rop(), rdy, rb(),
              ev(0, 4'b0010, 1, st, 0, ld, st, 0, 0, st & rdy, 0), "mem");
          if (rdy) break;
        end
        if (w >= MEM_TO) trap_cycles();
        else if (ld) cyc(1'b1, rb(), rop(), rb(), rb(), ev(0, 4'b0, 0, 0, 0, 0, 0, 1, 1, 1, 0), "wb_ld");
      end
    endcase
  endtask

  // Monitor: outputs are presented every cycle; compare each against the queued expectation.
  initial begin
    logic [13:0] e;
    string       t;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL %s: got %b, required %b", t, act, e);
        end
      end
    end
  end

  initial begin
    logic [10:0] op;
    int          sel;
    reset_pulse();

    run_instr(11'b10001011000, 0, 2, -1);        // ADD
    run_instr(11'b11001011000, 0, 2, -1);        // SUB
    run_instr(11'b10001010000, 0, 2, -1);        // AND
    run_instr(11'b10101010000, 0, 2, -1);        // ORR
    run_instr(11'b11111000010, 2, 2, -1);        // LDUR, ready on third MEM cycle
    run_instr(11'b10110100101, 0, 1, -1);        // CBZ taken
    run_instr(11'b10110100000, 0, 0, -1);        // CBZ not taken
    run_instr(11'b00010111111, 0, 2, -1);        // B
    run_instr(11'b11111000000, 15, 2, -1);       // STUR, ready on the limit cycle
    run_instr(11'b11111000000, 100, 2, -1);      // STUR, never ready -> trap
    run_instr(11'h000, 0, 2, -1);                // illegal -> trap
    run_instr(11'b11111000010, 5, 2, 1);         // LDUR aborted by reset in MEM

    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 8);
      case (sel)
        0: op = 11'b10001011000;
        1: op = 11'b11001011000;
        2: op = 11'b10001010000;
        3: op = 11'b10101010000;
        4: op = 11'b11111000010;
        5: op = 11'b11111000000;
        6: op = {8'b10110100, 3'($urandom)};
        7: op = {6'b000101, 5'($urandom)};
        default: op = rop();
      endcase
      run_instr(op, $urandom_range(0, 18), 2,
                ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1);
    end

    repeat (2) @(negedge CLK);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
